arb_packet_mux: RTL

Packet-level data mux downstream of the round-robin queue arbiter. It samples the arbiter's grant vector, locks onto the granted client for one whole packet, and forwards that client's valid/ready beat stream through a single-entry output register to one shared sink. It emits a per-client `pkt_done` pulse so the client can drop its request and the arbiter can move on.

---
 rtl/arb_packet_mux.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/arb_packet_mux.sv
// Packet-level mux behind the round-robin arbiter: locks onto one granted client per packet
// and forwards its beats through a single-entry output register. Optional idle timeout: ARB_PACKET_MUX_TIMEOUT_EN.
module arb_packet_mux #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   grant,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  input  logic           out_ready,
  output logic [N-1:0]   owner,
  output logic [N-1:0]   pkt_done,
  output logic [N-1:0]   timeout_err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t         state_reg, state_next;
  logic [N-1:0]   owner_reg, owner_next;
  logic [N-1:0]   pkt_done_reg, pkt_done_next;
  logic           out_valid_reg;
  logic           out_last_reg;
  logic [W-1:0]   out_data_reg;

  logic [N-1:0]   grant_low;
  logic [W-1:0]   masked_data [N];
  logic [W-1:0]   owner_data;
  logic           owner_valid;
  logic           owner_last;
  logic           slot_free;
  logic           accept;
  logic           timeout_hit;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("arb_packet_mux: TIMEOUT must be at least 1");
  end

  // Isolate the lowest set grant bit so a non-one-hot grant still picks one owner.
  assign grant_low = grant & (~grant + ONE);

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign masked_data[gi] = owner_reg[gi] ? in_data[gi*W +: W] : '0;
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N; i++) begin
      owner_data = owner_data | masked_data[i];
    end
  end

  assign owner_valid = |(in_valid & owner_reg);
  assign owner_last  = |(in_last & owner_reg);
  assign slot_free   = !out_valid_reg || out_ready;
  assign accept      = (state_reg == LOCKED) && owner_valid && slot_free;
  assign in_ready    = ((state_reg == LOCKED) && slot_free) ? owner_reg : '0;

`ifdef ARB_PACKET_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] idle_cnt_reg, idle_cnt_next;
  logic [N-1:0]  timeout_err_reg, timeout_err_next;

  // Counts consecutive locked cycles in which the owner offers nothing.
  always_comb begin
    idle_cnt_next = '0;
    timeout_hit   = 1'b0;
    if (state_reg == LOCKED && !owner_valid) begin
      idle_cnt_next = idle_cnt_reg + CW'(1);
      if (idle_cnt_next == CW'(TIMEOUT)) begin
        timeout_hit   = 1'b1;
        idle_cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt_reg    <= '0;
      timeout_err_reg <= '0;
    end else begin
      idle_cnt_reg    <= idle_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = '0;
`endif

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    pkt_done_next = '0;
`ifdef ARB_PACKET_MUX_TIMEOUT_EN
    timeout_err_next = '0;
`endif
    case (state_reg)
      IDLE: begin
        if (|grant) begin
          state_next = LOCKED;
          owner_next = grant_low;
        end
      end
      LOCKED: begin
        if (accept && owner_last) begin
          state_next    = IDLE;
          owner_next    = '0;
          pkt_done_next = owner_reg;
        end else if (timeout_hit) begin
          state_next = IDLE;
          owner_next = '0;
`ifdef ARB_PACKET_MUX_TIMEOUT_EN
          timeout_err_next = owner_reg;
`endif
        end
      end
      default: begin
        state_next = IDLE;
        owner_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      pkt_done_reg <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      pkt_done_reg <= pkt_done_next;
    end
  end

  // Load wins over drain, giving one beat per cycle when the sink keeps up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= owner_data;
      out_last_reg  <= owner_last;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign owner     = owner_reg;
  assign pkt_done  = pkt_done_reg;

endmodule
